// File: rtl/seg_pkg.sv
// Shared constants for seven-segment drivers: hex glyph table and blank pattern.
// Patterns are active-high, bit order {g,f,e,d,c,b,a}.
package seg_pkg;

  localparam logic [6:0] SegBlank = 7'h00;

  // Index 15 is leftmost; 6 and 9 carry tails, b and d are lowercase.
  localparam logic [15:0][6:0] HexGlyph = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/hex7seg.sv
// Combinational hex nibble to active-high seven-segment pattern {g,f,e,d,c,b,a}.
module hex7seg
  import seg_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  always_comb begin
    seg = HexGlyph[nib];
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scan controller: prescaled digit slots with anode dead-time,
// per-frame input snapshot, leading-zero suppression and registered polarity-adjusted outputs.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int unsigned N_DIG       = 4,
  parameter int unsigned DIV         = 50000,
  parameter int unsigned BLANK_CYC   = 16,
  parameter bit          AN_ACT_LOW  = 1'b1,
  parameter bit          SEG_ACT_LOW = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       ce,
  input  logic [4*N_DIG-1:0]         data,
  input  logic [N_DIG-1:0]           dp_in,
  input  logic [N_DIG-1:0]           dig_en,
  input  logic                       lz_en,
  output logic [N_DIG-1:0]           an,
  output logic [6:0]                 seg,
  output logic                       seg_dp,
  output logic [$clog2(N_DIG)-1:0]   idx,
  output logic                       frame_start
);

  localparam int unsigned IW = $clog2(N_DIG);
  localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [IW-1:0]    IdxLast  = IW'(N_DIG - 1);
  localparam logic [PW-1:0]    PcntLast = PW'(DIV - 1);
  localparam logic [N_DIG-1:0] AnOff    = AN_ACT_LOW ? {N_DIG{1'b1}} : {N_DIG{1'b0}};
  localparam logic [6:0]       SegOff   = SEG_ACT_LOW ? ~SegBlank : SegBlank;
  localparam logic             DpOff    = SEG_ACT_LOW;

  logic [PW-1:0]      pcnt_q, pcnt_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic               fs_q;
  logic               wrap;
  logic               pend_q;
  logic               snap_load;
  logic [4*N_DIG-1:0] data_s_q;
  logic [N_DIG-1:0]   dp_s_q, en_s_q;
  logic               lz_s_q;

  logic [3:0]         nib;
  logic [6:0]         glyph;
  logic               zero_above, suppress, in_blank;
  logic [N_DIG-1:0]   an_hi;
  logic [6:0]         seg_hi;
  logic               dp_hi;
  logic [N_DIG-1:0]   an_q;
  logic [6:0]         seg_q;
  logic               dp_q;

  // Prescaler and slot sequencer.
  always_comb begin
    pcnt_d = pcnt_q;
    idx_d  = idx_q;
    wrap   = 1'b0;
    if (ce) begin
      if (pcnt_q == PcntLast) begin
        pcnt_d = '0;
        if (idx_q == IdxLast) begin
          idx_d = '0;
          wrap  = 1'b1;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end else begin
        pcnt_d = pcnt_q + PW'(1);
      end
    end
  end

  // pend_q forces a snapshot on the first ce cycle after reset, before any wrap.
  assign snap_load = ce & (pend_q | wrap);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt_q   <= '0;
      idx_q    <= '0;
      fs_q     <= 1'b0;
      pend_q   <= 1'b1;
      data_s_q <= '0;
      dp_s_q   <= '0;
      en_s_q   <= '0;
      lz_s_q   <= 1'b0;
    end else begin
      pcnt_q <= pcnt_d;
      idx_q  <= idx_d;
      fs_q   <= wrap;
      if (snap_load) begin
        pend_q   <= 1'b0;
        data_s_q <= data;
        dp_s_q   <= dp_in;
        en_s_q   <= dig_en;
        lz_s_q   <= lz_en;
      end
    end
  end

  assign nib = data_s_q[4*idx_q +: 4];

  hex7seg u_hex7seg (
    .nib (nib),
    .seg (glyph)
  );

  // Digit is suppressed when it and every more-significant nibble are zero.
  always_comb begin
    zero_above = 1'b1;
    for (int i = 0; i < int'(N_DIG); i++) begin
      if (i >= int'(idx_q) && data_s_q[4*i +: 4] != 4'h0) begin
        zero_above = 1'b0;
      end
    end
    suppress = lz_s_q && (idx_q != '0) && zero_above;
    in_blank = 32'(pcnt_q) < BLANK_CYC;
    an_hi    = '0;
    if (!in_blank && en_s_q[idx_q] && (!suppress || dp_s_q[idx_q])) begin
      an_hi[idx_q] = 1'b1;
    end
    seg_hi = suppress ? SegBlank : glyph;
    dp_hi  = dp_s_q[idx_q];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_q  <= AnOff;
      seg_q <= SegOff;
      dp_q  <= DpOff;
    end else begin
      an_q  <= AN_ACT_LOW ? ~an_hi : an_hi;
      seg_q <= SEG_ACT_LOW ? ~seg_hi : seg_hi;
      dp_q  <= SEG_ACT_LOW ? ~dp_hi : dp_hi;
    end
  end

  assign an          = an_q;
  assign seg         = seg_q;
  assign seg_dp      = dp_q;
  assign idx         = idx_q;
  assign frame_start = fs_q;

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 SHALL have parameter N_DIG, default 4, number of multiplexed digits (2..8).
REQ-002 SHALL have parameter DIV, default 50000, ce-qualified clk cycles per digit slot (>= BLANK_CYC+2).
REQ-003 SHALL have parameter BLANK_CYC, default 16, anode dead-time in ce-qualified cycles at the start of each slot (0 allowed).
REQ-004 SHALL have parameter AN_ACT_LOW, default 1; 1 means anodes are driven active-low.
REQ-005 SHALL have parameter SEG_ACT_LOW, default 1; 1 means segments and dp are driven active-low.
REQ-006 clk  in  1  single clock; all state on its rising edge.
REQ-007 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-008 ce  in  1  clock enable; prescaler advances only when ce=1.
REQ-009 data  in  4*N_DIG  hex nibbles; nibble i (bits 4i+3:4i) is digit i, digit 0 rightmost.
REQ-010 dp_in  in  N_DIG  decimal point request per digit.
REQ-011 dig_en  in  N_DIG  per-digit enable; 0 keeps that anode inactive in its slot.
REQ-012 lz_en  in  1  leading-zero suppression enable.
REQ-013 an  out  N_DIG  anode drive, one-hot active or all inactive.
REQ-014 seg  out  7  segments {g,f,e,d,c,b,a}.
REQ-015 seg_dp  out  1  decimal point drive.
REQ-016 idx  out  $clog2(N_DIG)  index of the current slot.
REQ-017 frame_start  out  1  one-clk pulse when idx wraps to 0.

Function
REQ-018 Prescaler pcnt SHALL count 0..DIV-1 on ce=1 and hold on ce=0; slot advance occurs on the ce cycle where pcnt=DIV-1.
REQ-019 On slot advance, idx SHALL increment, wrapping N_DIG-1 -> 0, and pcnt SHALL return to 0.
REQ-020 frame_start SHALL be 1 for exactly the clk cycle after idx becomes 0, else 0.
REQ-021 data, dp_in, dig_en, lz_en SHALL be snapshotted into a frame register on every wrap to 0; a frame displays only snapshot values (no tearing).
REQ-022 While pcnt < BLANK_CYC, all anodes SHALL be inactive; seg and seg_dp SHALL already carry the new digit's pattern.
REQ-023 While pcnt >= BLANK_CYC, an[idx] SHALL be active iff snapshot dig_en[idx]=1 and the digit is not suppressed; all others inactive.
REQ-024 Leading-zero suppression: with lz_en=1, digit i>0 SHALL be suppressed iff nibbles N_DIG-1..i are all 0; digit 0 is never suppressed; a suppressed digit with dp set SHALL still light only the dp (anode active, seg all off).
REQ-025 Decode SHALL map 0-F to standard hex glyphs (b,d lowercase; 6,9 with tails).
REQ-026 an, seg, seg_dp SHALL be registered; polarity applied at the output register per AN_ACT_LOW/SEG_ACT_LOW.
REQ-027 Output latency SHALL be 1 clk from pcnt/idx state to pins.
REQ-028 ce=0 mid-slot SHALL freeze pcnt, idx and outputs (display holds current digit).

Reset
REQ-029 rst_n=0 SHALL asynchronously force pcnt=0, idx=0, frame_start=0, snapshot=all-zero, an all inactive, seg and seg_dp off (per polarity).
REQ-030 After rst_n deasserts, first slot SHALL be idx=0 with snapshot loaded on the first clk edge with ce=1.
REQ-031 Reset mid-slot SHALL abandon the slot with no residual anode pulse.

Structure
REQ-032 Shared package seg_pkg SHALL hold the 16-entry hex-to-segment constant table and the active-high blank constant.
REQ-033 Sub-module hex7seg (combinational nibble -> 7-bit active-high pattern) SHALL be instantiated once, fed by the muxed snapshot nibble.
REQ-034 Prescaler, slot sequencer, snapshot, suppression logic and output registers SHALL reside in seg_scan_ctrl.

Verification
REQ-035 N_DIG=4, DIV=8, BLANK_CYC=2, ce=1, data=16'h1234, dig_en=4'hF -> an cycles 1110,1101,1011,0111, each active 6 clk after 2 clk all-1111; seg=~glyph(4,3,2,1) per slot; frame_start every 32 clk.
REQ-036 data=16'h0050, lz_en=1 -> digits 3,2 anodes stay inactive, digits 1,0 show 5,0; lz_en=0 -> all four lit showing 0,0,5,0.
REQ-037 data=16'h0000, lz_en=1, dp_in=4'b0100 -> digit 0 shows 0; digit 2 anode active with seg all off, seg_dp active; digits 3,1 dark.
REQ-038 Change data from 16'h1111 to 16'h2222 mid-frame at idx=2 -> remaining slots of that frame show 1; next frame (after frame_start) shows 2.
REQ-039 ce toggling 1-in-3, DIV=8 -> slot length 24 clk; ce=0 held 100 clk -> an/seg/idx unchanged.
REQ-040 rst_n pulsed low mid-slot asynchronously -> an=1111, seg=7'h7F, idx=0 immediately before next edge; AN_ACT_LOW=0/SEG_ACT_LOW=0 build -> inactive levels become 0.
